pal_cfg_loader: RTL
===================

PAL_CFG_LOADER -- requirements
Module: pal_cfg_loader

Interface
REQ-001 SHALL have parameter SR_LEN, default 192, meaning the total number of configuration bits to emit (PAL chain length).
REQ-002 SHALL have parameter W, default 8, meaning the width of the parallel input word; legal range 1 <= W <= SR_LEN.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port CLK, input, 1 bit, the clock, with all state updated on the rising edge.
REQ-005 SHALL have port RES, input, 1 bit, the synchronous active-high reset.
REQ-006 SHALL have port START, input, 1 bit, a request to begin a new load.
REQ-007 SHALL have port ABORT, input, 1 bit, a request to cancel the load in progress.
REQ-008 SHALL have port IN_DATA, input, W bits, the configuration word.
REQ-009 SHALL have port IN_VALID, input, 1 bit, which qualifies IN_DATA.
REQ-010 SHALL have port IN_READY, output, 1 bit, indicating the loader accepts a word.
REQ-011 SHALL have port CFG_OUT, output, 1 bit, the serial configuration bit driven to the chain's CFG input.
REQ-012 SHALL have port EN_OUT, output, 1 bit, the shift enable driven to the chain's EN input.
REQ-013 SHALL have port BUSY, output, 1 bit, high in every state other than IDLE.
REQ-014 SHALL have port DONE, output, 1 bit, a one-cycle pulse when a load completes.
REQ-015 SHALL have port CRC, output, 8 bits, the checksum of the emitted bitstream.

Function
REQ-016 SHALL implement a state machine with the states IDLE, LOAD, SHIFT and FIN.
REQ-017 SHALL, in IDLE with START=1, move to LOAD, clear the bit counter and clear CRC; START SHALL be ignored in every other state.
REQ-018 SHALL drive IN_READY=1 only in LOAD; on IN_VALID & IN_READY it SHALL capture IN_DATA into the shift register and move to SHIFT.
REQ-019 SHALL, in SHIFT, drive EN_OUT=1 and CFG_OUT=shreg[0], shift the register right by one per cycle and increment the bit counter; words are emitted LSB first.
REQ-020 SHALL drive EN_OUT and CFG_OUT from registers only; EN_OUT=0 and CFG_OUT=0 outside SHIFT.
REQ-021 SHALL provide this latency: a word accepted at edge k has bit i on CFG_OUT in cycle k+1+i.
REQ-022 SHALL leave SHIFT after W bits of the current word, or as soon as the total reaches SR_LEN, whichever comes first: to FIN when the total equals SR_LEN, otherwise to LOAD.
REQ-023 SHALL discard the unused upper bits of the final word when SR_LEN is not a multiple of W.
REQ-024 SHALL hold EN_OUT=1 for exactly SR_LEN cycles per completed load; the LOAD gaps between words hold EN_OUT=0.
REQ-025 SHALL, in FIN, assert DONE for one cycle and return to IDLE on the next edge.
REQ-026 SHALL, on ABORT=1 in any non-IDLE state, go to IDLE on the next edge with no DONE pulse and with CRC holding its value; ABORT SHALL take priority over a handshake in the same cycle.
REQ-027 SHALL size the bit counter at $clog2(SR_LEN+1) bits, with no wrap.

Reset
REQ-028 SHALL, on RES=1 at a clock edge, force state=IDLE, shreg=0, counter=0, CRC=8'h00, IN_READY=0, EN_OUT=0, CFG_OUT=0, BUSY=0 and DONE=0.
REQ-029 SHALL give RES priority over START, ABORT and the handshake, and SHALL obey RES mid-load in the same way.

Configuration
REQ-030 SHALL, with PAL_CFG_CRC_EN defined, update CRC on every SHIFT cycle using CRC-8 with polynomial 0x07 and init 0x00: fb = CRC[7] ^ CFG_OUT, CRC = {CRC[6:0],0} ^ (fb ? 8'h07 : 8'h00).
REQ-031 SHALL, without PAL_CFG_CRC_EN, keep the CRC port present and tie it constantly to 8'h00, with no CRC logic present.

Verification
REQ-032 SHALL cover this scenario: SR_LEN=8, W=8, START, word 0x01 -> CFG_OUT stream 1,0,0,0,0,0,0,0 with EN_OUT high for 8 cycles, then one-cycle DONE, and CRC=0x89 (macro on) or 0x00 (macro off).
REQ-033 SHALL cover this scenario: defaults, 24 words 0xA5 -> EN_OUT high for exactly 192 cycles, CFG_OUT repeating 1,0,1,0,0,1,0,1, and DONE once.
REQ-034 SHALL cover this scenario: SR_LEN=10, W=4, words 0xF, 0x0, 0xF -> emitted bits 1111 0000 11, the upper 2 bits of the third word dropped, and DONE after the 10th bit.
REQ-035 SHALL cover this scenario: IN_VALID withheld for 5 cycles in LOAD -> EN_OUT=0 and IN_READY=1 throughout, with no bit lost when the stream resumes.
REQ-036 SHALL cover this scenario: ABORT asserted at bit 50 of 192 -> IDLE on the next edge, no DONE, and BUSY=0; a subsequent START then restarts with CRC cleared.
REQ-037 SHALL cover this scenario: RES asserted mid-SHIFT together with START -> all outputs at their reset values on the next cycle, with START ignored.

Source files
------------

// File: rtl/pal_cfg_loader.sv
// ---------------------------------------------------------------------------
// pal_cfg_loader
//
// Purpose
//   Loads a PAL configuration chain of SR_LEN bits. Configuration words of W
//   bits arrive on a valid/ready stream. Each word is shifted out LSB first on
//   CFG_OUT, with EN_OUT high for every emitted bit. When the last chain bit
//   has been emitted, DONE pulses for one cycle. Any upper bits of the final
//   word that would overrun the chain are dropped.
//
// Optional feature
//   PAL_CFG_CRC_EN : when defined, CRC carries a running CRC-8 (poly 0x07,
//                    init 0x00) over the emitted bitstream. When undefined,
//                    CRC is tied to 8'h00 and no checksum logic is built.
//
// Handshake
//   A word transfers on a rising edge where IN_VALID and IN_READY are both 1.
//   IN_READY is a pure function of state (high only while waiting for a
//   word), so it never depends on IN_VALID. ABORT in the same cycle wins and
//   the word is not taken.
//
// Ports
//   CLK       in   clock, all state changes on the rising edge
//   RES       in   synchronous active-high reset (highest priority)
//   START     in   begin a new load (honoured only in IDLE)
//   ABORT     in   cancel the load in progress (ignored in IDLE)
//   IN_DATA   in   [W-1:0] configuration word
//   IN_VALID  in   qualifies IN_DATA
//   IN_READY  out  loader accepts a word this cycle
//   CFG_OUT   out  serial configuration bit (registered)
//   EN_OUT    out  chain shift enable (registered)
//   BUSY      out  high in every state except IDLE
//   DONE      out  one-cycle pulse when a load completes
//   CRC       out  [7:0] checksum of the emitted bitstream
//   DBG_STATE out  [1:0] current FSM state (0 IDLE, 1 LOAD, 2 SHIFT, 3 FIN)
// ---------------------------------------------------------------------------
module pal_cfg_loader #(
    parameter int SR_LEN = 192,
    parameter int W      = 8
) (
    input  logic         CLK,
    input  logic         RES,
    input  logic         START,
    input  logic         ABORT,
    input  logic [W-1:0] IN_DATA,
    input  logic         IN_VALID,
    output logic         IN_READY,
    output logic         CFG_OUT,
    output logic         EN_OUT,
    output logic         BUSY,
    output logic         DONE,
    output logic [7:0]   CRC,
    output logic [1:0]   DBG_STATE
);

    localparam int CNT_W = $clog2(SR_LEN + 1);
    localparam int WC_W  = $clog2(W + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SR_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(W);
    localparam logic [WC_W-1:0]  WC_ONE   = WC_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    logic [1:0]       state;
    logic [W-1:0]     shreg;
    logic [W-1:0]     shreg_next;
    logic [CNT_W-1:0] bit_cnt;   // chain bits placed on CFG_OUT so far
    logic [WC_W-1:0]  word_cnt;  // bits of the current word placed so far
    logic             cfg_q;
    logic             en_q;
    logic             word_end;
    logic             chain_end;
    logic             abort_now;

    // shreg[0] is the bit currently on CFG_OUT; the next bit is shreg[1].
    assign shreg_next = shreg >> 1;
    assign word_end   = (word_cnt == WC_LAST);
    assign chain_end  = (bit_cnt == CNT_LAST);
    assign abort_now  = ABORT && (state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (RES) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            cfg_q    <= 1'b0;
            en_q     <= 1'b0;
        end else if (abort_now) begin
            state <= ST_IDLE;
            cfg_q <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        state    <= ST_LOAD;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    // Bit 0 goes straight to the output register so it is
                    // visible in the cycle right after the accepting edge.
                    if (IN_VALID) begin
                        shreg    <= IN_DATA;
                        cfg_q    <= IN_DATA[0];
                        en_q     <= 1'b1;
                        bit_cnt  <= bit_cnt + CNT_ONE;
                        word_cnt <= WC_ONE;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The chain limit can cut a word short; the remaining
                    // upper bits of that word are simply never emitted.
                    if (word_end || chain_end) begin
                        cfg_q <= 1'b0;
                        en_q  <= 1'b0;
                        state <= chain_end ? ST_FIN : ST_LOAD;
                    end else begin
                        shreg    <= shreg_next;
                        cfg_q    <= shreg_next[0];
                        bit_cnt  <= bit_cnt + CNT_ONE;
                        word_cnt <= word_cnt + WC_ONE;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PAL_CFG_CRC_EN
    logic [7:0] crc_q;
    logic       crc_fb;

    // The checksum folds in the bit actually on CFG_OUT during each SHIFT
    // cycle; an abort freezes it at its last value.
    assign crc_fb = crc_q[7] ^ cfg_q;

    always_ff @(posedge CLK) begin
        if (RES) begin
            crc_q <= 8'h00;
        end else if (abort_now) begin
            crc_q <= crc_q;
        end else if ((state == ST_IDLE) && START) begin
            crc_q <= 8'h00;
        end else if (state == ST_SHIFT) begin
            crc_q <= {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
        end
    end

    assign CRC = crc_q;
`else
    assign CRC = 8'h00;
`endif

    assign IN_READY  = (state == ST_LOAD);
    assign BUSY      = (state != ST_IDLE);
    assign DONE      = (state == ST_FIN);
    assign EN_OUT    = en_q;
    assign CFG_OUT   = cfg_q;
    assign DBG_STATE = state;

endmodule
